// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end with a 2-entry {instruction, pc} buffer and redirect handling
// Ports:
//   clock, reset_n            rising-edge clock, asynchronous active-low reset
//   imem_req/imem_addr        fetch request and word-aligned address, held until imem_ack
//   imem_ack/imem_data        memory completion and instruction word
//   redirect/redirect_pc      taken branch/jump and its target
//   instr_valid/instruction/instr_pc/instr_ready   head of buffer toward the CPU
//   err_misaligned            registered pulse for a redirect target with nonzero low bits
module fetch_unit #(
    parameter logic [31:0] reset_pc = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    output logic        err_misaligned
);
    typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;
    state_t      state;
    logic [31:0] addr;
    // target remembered while a stale request is still outstanding
    logic [31:0] tgt;
    logic [31:0] fifo_ins [2];
    logic [31:0] fifo_pc [2];
    logic        rd_ptr, wr_ptr;
    logic [1:0]  count, count_next;
    logic        pop, push;
    logic [31:0] target;
    assign target      = {redirect_pc[31:2], 2'b00};
    assign instr_valid = count != 2'd0;
    assign pop         = instr_valid && instr_ready;
    assign push        = state == REQ && imem_ack && !redirect;
    assign count_next  = redirect ? 2'd0 : count + {1'b0, push} - {1'b0, pop};
    assign imem_req    = state != IDLE;
    assign imem_addr   = addr;
    assign instruction = fifo_ins[rd_ptr];
    assign instr_pc    = fifo_pc[rd_ptr];
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            addr           <= reset_pc;
            tgt            <= reset_pc;
            count          <= 2'd0;
            rd_ptr         <= 1'b0;
            wr_ptr         <= 1'b0;
            fifo_ins[0]    <= 32'd0;
            fifo_ins[1]    <= 32'd0;
            fifo_pc[0]     <= 32'd0;
            fifo_pc[1]     <= 32'd0;
            err_misaligned <= 1'b0;
        end else begin
            err_misaligned <= redirect && (redirect_pc[1:0] != 2'b00);
            count          <= count_next;
            if (redirect) begin
                rd_ptr <= 1'b0;
                wr_ptr <= 1'b0;
            end else begin
                if (push) begin
                    fifo_ins[wr_ptr] <= imem_data;
                    fifo_pc[wr_ptr]  <= addr;
                    wr_ptr           <= ~wr_ptr;
                end
                if (pop)
                    rd_ptr <= ~rd_ptr;
            end
            case (state)
                IDLE: begin
                    if (redirect)
                        addr <= target;
                    // count_next reaches 2 only when the buffer stays full
                    state <= count_next[1] ? IDLE : REQ;
                end
                REQ: begin
                    if (redirect) begin
                        if (imem_ack)
                            addr <= target;
                        else
                            tgt <= target;
                        state <= imem_ack ? REQ : DISCARD;
                    end else if (imem_ack) begin
                        addr  <= addr + 32'd4;
                        state <= count_next[1] ? IDLE : REQ;
                    end
                end
                DISCARD: begin
                    if (redirect)
                        tgt <= target;
                    if (imem_ack) begin
                        addr  <= redirect ? target : tgt;
                        state <= REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit
module tb_fetch_unit;
    localparam logic [31:0] key = 32'hA5A5_5A5A;
    logic        clock, reset_n;
    logic        imem_req, imem_ack, redirect, instr_valid, instr_ready, err_misaligned;
    logic [31:0] imem_addr, imem_data, redirect_pc, instruction, instr_pc;
    logic        use_dead;
    logic        w_req, w_valid, w_err;
    logic [31:0] w_addr, w_ins, w_pc;
    logic [31:0] sb[$];
    logic        exp_err;
    int          total, bad;

    fetch_unit u_dut (
        .clock(clock), .reset_n(reset_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instruction(instruction), .instr_pc(instr_pc),
        .instr_ready(instr_ready), .err_misaligned(err_misaligned)
    );

    fetch_unit #(.reset_pc(32'hFFFF_FFFC)) u_wrap (
        .clock(clock), .reset_n(reset_n),
        .imem_req(w_req), .imem_addr(w_addr), .imem_ack(1'b1), .imem_data(32'h0),
        .redirect(1'b0), .redirect_pc(32'h0),
        .instr_valid(w_valid), .instruction(w_ins), .instr_pc(w_pc),
        .instr_ready(1'b1), .err_misaligned(w_err)
    );

    assign imem_data = use_dead ? 32'hDEAD_BEEF : imem_addr ^ key;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    function automatic void refill(input logic [31:0] p);
        sb.delete();
        for (int i = 0; i < 128; i++)
            sb.push_back(p + 32'(4 * i));
    endfunction

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        if (!reset_n) begin
            exp_err = 1'b0;
        end else begin
            check("err", {31'b0, err_misaligned}, {31'b0, exp_err});
            exp_err = redirect && (redirect_pc[1:0] != 2'b00);
            if (instr_valid && instr_ready) begin
                if (sb.size() == 0) begin
                    check("sb_size", 32'(sb.size()), 32'd1);
                end else begin
                    logic [31:0] e;
                    e = sb.pop_front();
                    check("pop_pc", instr_pc, e);
                    check("pop_ins", instruction, e ^ key);
                end
            end
            if (redirect)
                refill({redirect_pc[31:2], 2'b00});
        end
    end

    initial begin
        total = 0;
        bad = 0;
        exp_err = 1'b0;
        reset_n = 1'b0;
        imem_ack = 1'b1;
        instr_ready = 1'b1;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        use_dead = 1'b0;
        refill(32'h0);
        cyc();
        cyc();
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_err", {31'b0, err_misaligned}, 32'd0);
        check("rst_ins", instruction, 32'd0);
        check("rst_pc", instr_pc, 32'd0);
        check("rst_addr", imem_addr, 32'd0);
        reset_n = 1'b1;
        cyc();
        check("e1_req", {31'b0, imem_req}, 32'd1);
        check("e1_addr", imem_addr, 32'h0);
        check("e1_valid", {31'b0, instr_valid}, 32'd0);
        check("wrap_a0", w_addr, 32'hFFFF_FFFC);
        cyc();
        check("e2_addr", imem_addr, 32'h4);
        check("e2_valid", {31'b0, instr_valid}, 32'd1);
        check("e2_pc", instr_pc, 32'h0);
        check("wrap_a1", w_addr, 32'h0);
        cyc();
        check("e3_addr", imem_addr, 32'h8);
        check("e3_valid", {31'b0, instr_valid}, 32'd1);
        instr_ready = 1'b0;
        cyc();
        check("full_req", {31'b0, imem_req}, 32'd0);
        check("full_head", instr_pc, 32'h4);
        cyc();
        check("idle_req", {31'b0, imem_req}, 32'd0);
        check("idle_addr", imem_addr, 32'hC);
        instr_ready = 1'b1;
        cyc();
        check("pop1_req", {31'b0, imem_req}, 32'd1);
        check("pop1_addr", imem_addr, 32'hC);
        check("pop1_head", instr_pc, 32'h8);
        imem_ack = 1'b0;
        cyc();
        check("stall_valid", {31'b0, instr_valid}, 32'd0);
        check("stall_addr", imem_addr, 32'hC);
        redirect = 1'b1;
        redirect_pc = 32'h100;
        cyc();
        redirect = 1'b0;
        check("disc_req", {31'b0, imem_req}, 32'd1);
        check("disc_addr", imem_addr, 32'hC);
        cyc();
        check("disc_hold", imem_addr, 32'hC);
        use_dead = 1'b1;
        imem_ack = 1'b1;
        cyc();
        use_dead = 1'b0;
        check("disc_done", imem_addr, 32'h100);
        check("disc_drop", {31'b0, instr_valid}, 32'd0);
        cyc();
        check("tgt_pc", instr_pc, 32'h100);
        check("tgt_ins", instruction, 32'h100 ^ key);
        redirect = 1'b1;
        redirect_pc = 32'h200;
        cyc();
        redirect = 1'b0;
        check("rack_valid", {31'b0, instr_valid}, 32'd0);
        check("rack_addr", imem_addr, 32'h200);
        cyc();
        check("rack_pc", instr_pc, 32'h200);
        redirect = 1'b1;
        redirect_pc = 32'h203;
        cyc();
        redirect = 1'b0;
        check("mis_err", {31'b0, err_misaligned}, 32'd1);
        check("mis_addr", imem_addr, 32'h200);
        cyc();
        check("mis_clear", {31'b0, err_misaligned}, 32'd0);
        check("mis_next", imem_addr, 32'h204);
        imem_ack = 1'b0;
        cyc();
        #2;
        reset_n = 1'b0;
        refill(32'h0);
        #1;
        check("arst_req", {31'b0, imem_req}, 32'd0);
        check("arst_valid", {31'b0, instr_valid}, 32'd0);
        check("arst_addr", imem_addr, 32'h0);
        cyc();
        reset_n = 1'b1;
        imem_ack = 1'b1;
        cyc();
        check("rel_req", {31'b0, imem_req}, 32'd1);
        check("rel_addr", imem_addr, 32'h0);
        for (int i = 0; i < 80; i++) begin
            instr_ready = 1'($urandom_range(1, 0));
            imem_ack = $urandom_range(3, 0) != 0;
            redirect = $urandom_range(7, 0) == 0;
            redirect_pc = $urandom & 32'h0000_0FFF;
            cyc();
        end
        redirect = 1'b0;
        cyc();
        cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: reset_pc, 32'h0000_0000, first fetch address after reset; SHALL be word aligned.
REQ-002 clock  input  1  single rising-edge clock for all state.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 imem_req  output  1  instruction memory request; SHALL be held high until accepted.
REQ-005 imem_addr  output  32  word-aligned fetch address; SHALL be stable while imem_req is high.
REQ-006 imem_ack  input  1  memory response; transfer completes in any cycle where imem_req && imem_ack.
REQ-007 imem_data  input  32  instruction word, valid only in the completing cycle.
REQ-008 redirect  input  1  branch/jump taken by CPU; single-cycle pulse.
REQ-009 redirect_pc  input  32  new fetch address, sampled when redirect is high.
REQ-010 instr_valid  output  1  instruction/instr_pc valid toward CPU.
REQ-011 instruction  output  32  head instruction word, drives mips_cpu instruction input.
REQ-012 instr_pc  output  32  address of head instruction.
REQ-013 instr_ready  input  1  CPU accepts; pop when instr_valid && instr_ready.
REQ-014 err_misaligned  output  1  one-cycle pulse: redirect_pc[1:0] != 0.

Function
REQ-015 States SHALL be IDLE (no request), REQ (request live, response kept), DISCARD (request live, response dropped); imem_req = (state != IDLE), decoded from registered state only.
REQ-016 Buffer: 2-entry FIFO of {instruction, pc}; instr_valid = (count != 0); head entry drives instruction/instr_pc.
REQ-017 IDLE -> REQ on clock edge when count_next < 2 (count after this cycle's pop); otherwise stay IDLE.
REQ-018 REQ with imem_ack and no redirect: push {imem_data, imem_addr}; pc += 4 (mod 2^32, wrap 32'hFFFF_FFFC -> 0); next state REQ if count_next < 2, else IDLE.
REQ-019 REQ without imem_ack: hold state, imem_addr unchanged.
REQ-020 Redirect in REQ without imem_ack: -> DISCARD; pc <= {redirect_pc[31:2], 2'b00}.
REQ-021 Redirect in REQ with imem_ack same cycle: data not pushed; pc <= aligned redirect_pc; next state REQ.
REQ-022 DISCARD with imem_ack: data dropped, pc unchanged, -> REQ; new redirect in DISCARD only updates pc, state stays DISCARD until ack.
REQ-023 Redirect in IDLE: pc <= aligned redirect_pc; -> REQ.
REQ-024 Redirect flushes the FIFO: count_next = 0 regardless of push/pop; a pop in the redirect cycle counts as consumed (the branch itself).
REQ-025 Simultaneous push and pop: count unchanged, entries in order; push when full SHALL NOT occur (guaranteed by REQ-017/018).
REQ-026 Sustained throughput: one instruction per cycle when imem_ack is tied high and instr_ready is high.
REQ-027 err_misaligned registered: high the cycle after redirect with redirect_pc[1:0] != 0, else low.
REQ-028 Latency: data pushed on completing edge; instr_valid high the next cycle.

Reset
REQ-029 reset_n low asynchronously forces: state IDLE, count 0, pc = reset_pc, imem_req 0, instr_valid 0, err_misaligned 0; instruction/instr_pc 0.
REQ-030 Reset mid-request abandons the transfer; first edge after release -> REQ with imem_addr = reset_pc.

Verification
REQ-031 Reset release, imem_ack tied 1, instr_ready 1 -> addresses 0x0,0x4,0x8 on consecutive cycles; instr_valid continuous from third cycle.
REQ-032 instr_ready 0, ack 1 -> two entries buffered (pc 0x0,0x4), imem_req drops to 0; instr_ready 1 for one cycle -> one pop, next request 0x8.
REQ-033 Request to 0x10 stalled (ack 0), redirect to 0x100 -> state DISCARD, addr stays 0x10; ack with 0xDEADBEEF -> not delivered; next request addr 0x100.
REQ-034 Redirect with imem_ack same cycle, redirect_pc 0x200 -> acked word dropped, FIFO empty next cycle, next imem_addr 0x200.
REQ-035 Redirect to 0x203 -> err_misaligned pulses 1 cycle; fetch addr 0x200.
REQ-036 reset_pc = 32'hFFFF_FFFC, ack 1 -> fetch 0xFFFF_FFFC then 0x0000_0000.
